execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
Execute stage of the 5-stage pipelined RISC processor. It consumes the E-stage bundle produced by the decode stage and applies operand forwarding from the M and W stages. It computes the ALU result and Zero flag, resolves beq branches (PCSrcE, PCTargetE) back to fetch, and registers the M-stage bundle for the memory stage.

Parameters:
DATA_W, 32, datapath width (ALU, operands, PC)
REG_AW, 5, register address width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
RegWriteE  input  1  register-write enable of the E-stage instruction
ResultSrcE  input  1  1 = load result, 0 = ALU result
MemWriteE  input  1  store enable
ALUSrcE  input  1  1 = ImmExtE is operand B, 0 = forwarded RD2
BranchE  input  1  beq in E stage
ALUcontrolE  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt; other codes -> add
RdE  input  REG_AW  destination register
RD1E  input  DATA_W  rs1 value from register file
RD2E  input  DATA_W  rs2 value from register file
PCE  input  DATA_W  PC of the E-stage instruction
ImmExtE  input  DATA_W  sign-extended immediate
PCPlus4E  input  DATA_W  PC+4
ResultW  input  DATA_W  writeback result, forwarding source
ForwardAE  input  2  operand A select: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E
ForwardBE  input  2  same encoding for RD2E
PCSrcE  output  1  branch taken (combinational)
PCTargetE  output  DATA_W  branch target PCE+ImmExtE (combinational)
RegWriteM  output  1  registered RegWriteE
ResultSrcM  output  1  registered ResultSrcE
MemWriteM  output  1  registered MemWriteE
RdM  output  REG_AW  registered RdE
ALUResultM  output  DATA_W  registered ALU result
WriteDataM  output  DATA_W  registered forwarded operand B, before the ALUSrc mux
PCPlus4M  output  DATA_W  registered PCPlus4E

Behaviour:
- Operand path: SrcAE = mux(ForwardAE); fwdB = mux(ForwardBE); SrcBE = ALUSrcE ? ImmExtE : fwdB.
- The ALUResultM forwarding source is this block's own M register (internal feedback). There is no separate input for it.
- ALU results, modulo 2^DATA_W:
  - add: A+B; sub: A-B; and: A&B; or: A|B.
  - slt: signed compare, result 1 when A<B, otherwise 0, zero-extended to DATA_W.
  - Undefined codes behave as add.
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + ImmExtE. The sum wraps and does not depend on ALUSrcE.
- All M outputs are registered once: latency 1 clk from E inputs to M outputs. PCSrcE and PCTargetE have 0-cycle latency.
- Reset (rst=0, asynchronous assert, any time including mid-stream): all M outputs clear to 0 immediately.
  - Clearing RegWriteM and MemWriteM guarantees no spurious write after reset.
  - The first capture is on the first rising clk with rst=1. Deassertion is sampled synchronously by the external reset synchronizer.
- Forwarding is purely a mux; hazard detection, stall and flush belong to the hazard unit (not this block).
- Back-to-back dependent instructions: ForwardAE=10 selects the value ALUResultM holds at that moment, i.e. the previous instruction's result.
- The x0 policy is upstream: RdE=0 with RegWriteE=1 is passed through unchanged.
- No internal state beyond the M pipeline register.

Test Plan:
- Reset: assert rst=0 mid-run with RegWriteE=1 and MemWriteE=1 -> all M outputs 0 asynchronously. They stay 0 while rst=0; the first capture comes on the first edge after release.
- R-type add/sub/and/or/slt, no forwarding: RD1E=5, RD2E=2, ALUSrcE=0 -> ALUResultM = 7, 3, 0, 7, 0 on successive cycles.
  - slt with RD1E=32'hFFFFFFFB (-5) and RD2E=2 -> 1.
  - Each result appears 1 cycle after its inputs.
- lw/sw: ALUSrcE=1, RD1E=0x10, ImmExtE=0xFFFFFFFC, RD2E=0xAB, MemWriteE=1 -> ALUResultM=0x0C, WriteDataM=0xAB, MemWriteM=1.
- Forwarding: cycle 1 add gives ALUResultM=7. In cycle 2, ForwardAE=10 and ForwardBE=01 with ResultW=3, RD1E=RD2E=0, sub -> ALUResultM=4.
  - ForwardBE=11 with RD2E=9 -> RD2E is used.
- Branch: BranchE=1, ALUcontrolE=001, RD1E=RD2E=4, PCE=0x20, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0x18 in the same cycle.
  - RD2E=5 -> PCSrcE=0.
  - BranchE=0 with equal operands -> PCSrcE=0.
- Wrap: RD1E=0xFFFFFFFF, RD2E=1, add -> ALUResultM=0.
  - PCE=0xFFFFFFFC, ImmExtE=8 -> PCTargetE=0x4.

Source files
------------

// File: rtl/execute_cycle_if.sv
// E-stage inputs and M-stage outputs of the execute stage.
// The decode side drives E fields and the memory side consumes M fields.
interface execute_cycle_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              RegWriteE;
  logic              ResultSrcE;
  logic              MemWriteE;
  logic              ALUSrcE;
  logic              BranchE;
  logic [2:0]        ALUcontrolE;
  logic [REG_AW-1:0] RdE;
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [DATA_W-1:0] PCE;
  logic [DATA_W-1:0] ImmExtE;
  logic [DATA_W-1:0] PCPlus4E;
  logic [DATA_W-1:0] ResultW;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              PCSrcE;
  logic [DATA_W-1:0] PCTargetE;
  logic              RegWriteM;
  logic              ResultSrcM;
  logic              MemWriteM;
  logic [REG_AW-1:0] RdM;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] PCPlus4M;

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE,
    input  ALUSrcE, BranchE, ALUcontrolE,
    input  RdE, RD1E, RD2E, PCE, ImmExtE,
    input  PCPlus4E, ResultW,
    input  ForwardAE, ForwardBE,
    output PCSrcE, PCTargetE,
    output RegWriteM, ResultSrcM, MemWriteM,
    output RdM, ALUResultM, WriteDataM,
    output PCPlus4M
  );

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE,
    output ALUSrcE, BranchE, ALUcontrolE,
    output RdE, RD1E, RD2E, PCE, ImmExtE,
    output PCPlus4E, ResultW,
    output ForwardAE, ForwardBE,
    input  PCSrcE, PCTargetE,
    input  RegWriteM, ResultSrcM, MemWriteM,
    input  RdM, ALUResultM, WriteDataM,
    input  PCPlus4M
  );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: forwarding muxes, ALU, beq resolve
// and the E->M pipeline register.
module execute_cycle #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic             clk,
  input logic             rst,
  execute_cycle_if.slave  bus
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_res;
  logic              zero_e;

  logic              reg_write_d, reg_write_q;
  logic              result_src_d, result_src_q;
  logic              mem_write_d, mem_write_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic [DATA_W-1:0] write_data_d, write_data_q;
  logic [DATA_W-1:0] pc_plus4_d, pc_plus4_q;

  // Code 10 feeds back our own M register.
  always_comb begin
    src_a = bus.RD1E;
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = bus.RD1E;
    endcase
  end

  always_comb begin
    fwd_b = bus.RD2E;
    case (bus.ForwardBE)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = bus.RD2E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;

  always_comb begin
    alu_res = src_a + src_b;
    case (bus.ALUcontrolE)
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b101:  alu_res = {{(DATA_W-1){1'b0}},
                          $signed(src_a) < $signed(src_b)};
      default: alu_res = src_a + src_b;
    endcase
  end

  assign zero_e        = (alu_res == '0);
  assign bus.PCSrcE    = bus.BranchE & zero_e;
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

  always_comb begin
    reg_write_d  = bus.RegWriteE;
    result_src_d = bus.ResultSrcE;
    mem_write_d  = bus.MemWriteE;
    rd_d         = bus.RdE;
    alu_result_d = alu_res;
    write_data_d = fwd_b;
    pc_plus4_d   = bus.PCPlus4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      mem_write_q  <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      mem_write_q  <= mem_write_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign bus.RegWriteM  = reg_write_q;
  assign bus.ResultSrcM = result_src_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.RdM        = rd_q;
  assign bus.ALUResultM = alu_result_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases
// plus random traffic against a behavioural model.
module tb_execute_cycle;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_cycle_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

  execute_cycle #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] m_alu  = '0;

  function automatic logic [31:0] alu_ref(
    input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (ctl)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] pick(
    input logic [1:0] sel, input logic [31:0] rf,
    input logic [31:0] resw, input logic [31:0] malu);
    if (sel == 2'b01) return resw;
    if (sel == 2'b10) return malu;
    return rf;
  endfunction

  task automatic drive(
    input logic [2:0] ctl, input logic [31:0] rd1,
    input logic [31:0] rd2, input logic [31:0] imm,
    input logic [31:0] pc, input logic [31:0] resw,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic alusrc, input logic br,
    input logic regw, input logic memw,
    input logic ressrc, input logic [4:0] rd);
    bus.ALUcontrolE = ctl;
    bus.RD1E        = rd1;
    bus.RD2E        = rd2;
    bus.ImmExtE     = imm;
    bus.PCE         = pc;
    bus.PCPlus4E    = pc + 32'd4;
    bus.ResultW     = resw;
    bus.ForwardAE   = fa;
    bus.ForwardBE   = fb;
    bus.ALUSrcE     = alusrc;
    bus.BranchE     = br;
    bus.RegWriteE   = regw;
    bus.MemWriteE   = memw;
    bus.ResultSrcE  = ressrc;
    bus.RdE         = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    drive(3'd0, 32'd5, 32'd2, 32'd0, 32'h100, 32'd0,
          2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7);
    tick();
    tick();
    n_chk++;
    if ({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RdM,
         bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: alu=%h wd=%h rw=%b mw=%b want 0",
               bus.ALUResultM, bus.WriteDataM, bus.RegWriteM,
               bus.MemWriteM);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if (bus.ALUResultM !== 32'd7 || bus.RegWriteM !== 1'b1 ||
        bus.MemWriteM !== 1'b1 || bus.RdM !== 5'd7 ||
        bus.PCPlus4M !== 32'h104) begin
      n_fail++;
      $display("FAIL reset_first_capture: alu=%h rw=%b mw=%b rd=%0d want 7 1 1 7",
               bus.ALUResultM, bus.RegWriteM, bus.MemWriteM, bus.RdM);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RdM,
         bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: alu=%h rw=%b mw=%b want 0",
               bus.ALUResultM, bus.RegWriteM, bus.MemWriteM);
    end
    tick();
    n_chk++;
    if (bus.RegWriteM !== 1'b0 || bus.MemWriteM !== 1'b0 ||
        bus.ALUResultM !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_held: alu=%h rw=%b mw=%b want 0",
               bus.ALUResultM, bus.RegWriteM, bus.MemWriteM);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.RegWriteM !== 1'b0 || bus.ALUResultM !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release_early: alu=%h rw=%b want 0",
               bus.ALUResultM, bus.RegWriteM);
    end
    tick();
    n_chk++;
    if (bus.ALUResultM !== 32'd7 || bus.MemWriteM !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_capture: alu=%h mw=%b want 7 1",
               bus.ALUResultM, bus.MemWriteM);
    end
    m_alu = 32'd7;
  endtask

  task automatic test_rtype();
    logic [2:0]  ctl [6];
    logic [31:0] a   [6];
    logic [31:0] exp [6];
    ctl = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd5};
    a   = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'hFFFFFFFB};
    exp = '{32'd7, 32'd3, 32'd0, 32'd7, 32'd0, 32'd1};
    for (int i = 0; i < 6; i++) begin
      drive(ctl[i], a[i], 32'd2, 32'd0, 32'h40, 32'd0,
            2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'(i + 1));
      #1;
      n_chk++;
      if (bus.ALUResultM !== m_alu) begin
        n_fail++;
        $display("FAIL rtype_latency[%0d]: alu=%h want %h (previous)",
                 i, bus.ALUResultM, m_alu);
      end
      tick();
      n_chk++;
      if (bus.ALUResultM !== exp[i] || bus.RdM !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL rtype[%0d]: alu=%h rd=%0d want %h %0d",
                 i, bus.ALUResultM, bus.RdM, exp[i], i + 1);
      end
      m_alu = exp[i];
    end
  endtask

  task automatic test_mem();
    drive(3'd0, 32'h10, 32'hAB, 32'hFFFFFFFC, 32'h80, 32'd0,
          2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    tick();
    n_chk++;
    if (bus.ALUResultM !== 32'h0C || bus.WriteDataM !== 32'hAB ||
        bus.MemWriteM !== 1'b1 || bus.RegWriteM !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_sw: alu=%h wd=%h mw=%b rw=%b want 0c ab 1 0",
               bus.ALUResultM, bus.WriteDataM, bus.MemWriteM,
               bus.RegWriteM);
    end
    m_alu = 32'h0C;
  endtask

  task automatic test_forward();
    drive(3'd0, 32'd5, 32'd2, 32'd0, 32'h0, 32'd0,
          2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
    tick();
    drive(3'd1, 32'd0, 32'd0, 32'd0, 32'h4, 32'd3,
          2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
    tick();
    n_chk++;
    if (bus.ALUResultM !== 32'd4 || bus.WriteDataM !== 32'd3) begin
      n_fail++;
      $display("FAIL fwd_back_to_back: alu=%h wd=%h want 4 3",
               bus.ALUResultM, bus.WriteDataM);
    end
    drive(3'd1, 32'd20, 32'd9, 32'd0, 32'h8, 32'd100,
          2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
    tick();
    n_chk++;
    if (bus.ALUResultM !== 32'd11 || bus.WriteDataM !== 32'd9) begin
      n_fail++;
      $display("FAIL fwd_code11: alu=%h wd=%h want 0b 9",
               bus.ALUResultM, bus.WriteDataM);
    end
    m_alu = 32'd11;
  endtask

  task automatic test_branch();
    logic [31:0] rd2 [3];
    logic        br  [3];
    logic        exp [3];
    rd2 = '{32'd4, 32'd5, 32'd4};
    br  = '{1'b1, 1'b1, 1'b0};
    exp = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 32'd4, rd2[i], 32'hFFFFFFF8, 32'h20, 32'd0,
            2'b00, 2'b00, 1'b0, br[i], 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      n_chk++;
      if (bus.PCSrcE !== exp[i] || bus.PCTargetE !== 32'h18) begin
        n_fail++;
        $display("FAIL branch[%0d]: pcsrc=%b tgt=%h want %b 18",
                 i, bus.PCSrcE, bus.PCTargetE, exp[i]);
      end
      tick();
      m_alu = 32'd4 - rd2[i];
    end
  endtask

  task automatic test_wrap();
    drive(3'd0, 32'hFFFFFFFF, 32'd1, 32'd8, 32'hFFFFFFFC, 32'd0,
          2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
    #1;
    n_chk++;
    if (bus.PCTargetE !== 32'h4) begin
      n_fail++;
      $display("FAIL wrap_target: tgt=%h want 4", bus.PCTargetE);
    end
    tick();
    n_chk++;
    if (bus.ALUResultM !== 32'd0 || bus.PCPlus4M !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_add: alu=%h pc4=%h want 0 0",
               bus.ALUResultM, bus.PCPlus4M);
    end
    m_alu = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] rd1, rd2, imm, pc, resw, a, fb, b, res, tgt;
    logic [2:0]  ctl;
    logic [1:0]  fa, fbs;
    logic        alusrc, br, regw, memw, rs, pcs;
    logic [4:0]  rd;
    for (int i = 0; i < 300; i++) begin
      rd1    = $urandom;
      rd2    = ($urandom_range(0, 3) == 0) ? rd1 : $urandom;
      imm    = $urandom;
      pc     = $urandom;
      resw   = $urandom;
      ctl    = 3'($urandom_range(0, 7));
      fa     = 2'($urandom_range(0, 3));
      fbs    = 2'($urandom_range(0, 3));
      alusrc = 1'($urandom_range(0, 1));
      br     = 1'($urandom_range(0, 1));
      regw   = 1'($urandom_range(0, 1));
      memw   = 1'($urandom_range(0, 1));
      rs     = 1'($urandom_range(0, 1));
      rd     = 5'($urandom_range(0, 31));
      drive(ctl, rd1, rd2, imm, pc, resw, fa, fbs,
            alusrc, br, regw, memw, rs, rd);
      a   = pick(fa, rd1, resw, m_alu);
      fb  = pick(fbs, rd2, resw, m_alu);
      b   = alusrc ? imm : fb;
      res = alu_ref(ctl, a, b);
      pcs = br && (res == 32'd0);
      tgt = pc + imm;
      #1;
      n_chk++;
      if (bus.PCSrcE !== pcs || bus.PCTargetE !== tgt) begin
        n_fail++;
        $display("FAIL rand_branch[%0d]: pcsrc=%b tgt=%h want %b %h",
                 i, bus.PCSrcE, bus.PCTargetE, pcs, tgt);
      end
      tick();
      n_chk++;
      if (bus.ALUResultM !== res || bus.WriteDataM !== fb ||
          bus.RegWriteM !== regw || bus.MemWriteM !== memw ||
          bus.ResultSrcM !== rs || bus.RdM !== rd ||
          bus.PCPlus4M !== pc + 32'd4) begin
        n_fail++;
        $display("FAIL rand_m[%0d]: alu=%h wd=%h rd=%0d want %h %h %0d",
                 i, bus.ALUResultM, bus.WriteDataM, bus.RdM,
                 res, fb, rd);
      end
      m_alu = res;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_forward();
    test_branch();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
